// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one single-port synchronous memory among bus masters.
// Fixed-priority or round-robin grant, registered memory strobes, tagged read return.
module mem_arbiter #(
   parameter int unsigned P_chans      = 2,
   parameter int unsigned P_addr_bits  = 16,
   parameter int unsigned P_data_bits  = 8,
   parameter int unsigned P_rd_latency = 1,
   parameter bit          P_mode       = 1'b1
) (
   input  logic                             I_clock,
   input  logic                             I_reset,
   input  logic [P_chans-1:0]               I_req,
   input  logic [P_chans-1:0]               I_wren,
   input  logic [P_chans*P_addr_bits-1:0]   I_addr,
   input  logic [P_chans*P_data_bits-1:0]   I_wr_data,
   output logic [P_chans-1:0]               O_ack,
   output logic [P_chans-1:0]               O_rvalid,
   output logic [P_data_bits-1:0]           O_rd_data,
   output logic [P_addr_bits-1:0]           O_mem_addr,
   output logic                             O_mem_rden,
   output logic                             O_mem_wren,
   output logic [P_data_bits-1:0]           O_mem_data,
   input  logic [P_data_bits-1:0]           I_mem_data
);

   localparam int unsigned IdxW = (P_chans > 1) ? $clog2(P_chans) : 1;

   logic [P_chans-1:0]      eligible;
   logic                    gnt_valid;
   logic [IdxW-1:0]         gnt_idx;
   logic [IdxW-1:0]         cand_idx;
   int unsigned             cand;
   logic [IdxW-1:0]         ptr_q, ptr_d;
   logic [P_chans-1:0]      ack_d;
   logic [P_chans-1:0]      rvalid_d;
   // Channel index travelling alongside O_mem_rden; it seeds the tag pipeline.
   logic [IdxW-1:0]         gidx_q;
   logic [P_rd_latency-1:0] tag_vld_q;
   logic [IdxW-1:0]         tag_idx_q [P_rd_latency];

   always_comb begin
      // The channel acked this cycle sits out the next edge to avoid a double grant.
      eligible  = I_req & ~O_ack;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < P_chans; i++) begin
         cand     = P_mode ? (32'(ptr_q) + i) % P_chans : i;
         cand_idx = IdxW'(cand);
         if (!gnt_valid && eligible[cand_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx;
         end
      end

      ack_d = '0;
      if (gnt_valid) begin
         ack_d[gnt_idx] = 1'b1;
      end

      ptr_d = ptr_q;
      if (gnt_valid) begin
         ptr_d = (gnt_idx == IdxW'(P_chans - 1)) ? '0 : gnt_idx + 1'b1;
      end

      rvalid_d = '0;
      if (tag_vld_q[P_rd_latency-1]) begin
         rvalid_d[tag_idx_q[P_rd_latency-1]] = 1'b1;
      end
   end

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         O_ack      <= '0;
         O_rvalid   <= '0;
         O_rd_data  <= '0;
         O_mem_addr <= '0;
         O_mem_rden <= 1'b0;
         O_mem_wren <= 1'b0;
         O_mem_data <= '0;
         ptr_q      <= '0;
         gidx_q     <= '0;
         tag_vld_q  <= '0;
         for (int i = 0; i < P_rd_latency; i++) begin
            tag_idx_q[i] <= '0;
         end
      end else begin
         O_ack      <= ack_d;
         O_rvalid   <= rvalid_d;
         ptr_q      <= ptr_d;
         O_mem_rden <= gnt_valid & ~I_wren[gnt_idx];
         O_mem_wren <= gnt_valid & I_wren[gnt_idx];
         if (gnt_valid) begin
            O_mem_addr <= I_addr[32'(gnt_idx)*P_addr_bits +: P_addr_bits];
            O_mem_data <= I_wr_data[32'(gnt_idx)*P_data_bits +: P_data_bits];
            gidx_q     <= gnt_idx;
         end
         if (tag_vld_q[P_rd_latency-1]) begin
            O_rd_data <= I_mem_data;
         end
         tag_vld_q[0] <= O_mem_rden;
         tag_idx_q[0] <= gidx_q;
         for (int i = 1; i < P_rd_latency; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover round-robin with latency 2,
// round-robin over three channels, and fixed priority.
module tb_mem_arbiter;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: 2 channels, round-robin, read latency 2, small backing memory.
   logic [1:0]  a_req, a_wren, a_ack, a_rvalid;
   logic [31:0] a_addr;
   logic [15:0] a_wdata;
   logic [7:0]  a_rd_data, a_mem_data, a_mem_rdata;
   logic [15:0] a_mem_addr;
   logic        a_mem_rden, a_mem_wren;

   // Instance b: 3 channels, round-robin, read latency 1.
   logic [2:0]  b_req, b_wren, b_ack, b_rvalid;
   logic [47:0] b_addr;
   logic [23:0] b_wdata;
   logic [7:0]  b_rd_data, b_mem_data, b_mem_rdata;
   logic [15:0] b_mem_addr;
   logic        b_mem_rden, b_mem_wren;

   // Instance c: 2 channels, fixed priority, read latency 1.
   logic [1:0]  c_req, c_wren, c_ack, c_rvalid;
   logic [31:0] c_addr;
   logic [15:0] c_wdata;
   logic [7:0]  c_rd_data, c_mem_data, c_mem_rdata;
   logic [15:0] c_mem_addr;
   logic        c_mem_rden, c_mem_wren;

   mem_arbiter #(.P_chans(2), .P_addr_bits(16), .P_data_bits(8), .P_rd_latency(2),
                 .P_mode(1'b1)) u_a (
      .I_clock(clk), .I_reset(rst), .I_req(a_req), .I_wren(a_wren), .I_addr(a_addr),
      .I_wr_data(a_wdata), .O_ack(a_ack), .O_rvalid(a_rvalid), .O_rd_data(a_rd_data),
      .O_mem_addr(a_mem_addr), .O_mem_rden(a_mem_rden), .O_mem_wren(a_mem_wren),
      .O_mem_data(a_mem_data), .I_mem_data(a_mem_rdata));

   mem_arbiter #(.P_chans(3), .P_addr_bits(16), .P_data_bits(8), .P_rd_latency(1),
                 .P_mode(1'b1)) u_b (
      .I_clock(clk), .I_reset(rst), .I_req(b_req), .I_wren(b_wren), .I_addr(b_addr),
      .I_wr_data(b_wdata), .O_ack(b_ack), .O_rvalid(b_rvalid), .O_rd_data(b_rd_data),
      .O_mem_addr(b_mem_addr), .O_mem_rden(b_mem_rden), .O_mem_wren(b_mem_wren),
      .O_mem_data(b_mem_data), .I_mem_data(b_mem_rdata));

   mem_arbiter #(.P_chans(2), .P_addr_bits(16), .P_data_bits(8), .P_rd_latency(1),
                 .P_mode(1'b0)) u_c (
      .I_clock(clk), .I_reset(rst), .I_req(c_req), .I_wren(c_wren), .I_addr(c_addr),
      .I_wr_data(c_wdata), .O_ack(c_ack), .O_rvalid(c_rvalid), .O_rd_data(c_rd_data),
      .O_mem_addr(c_mem_addr), .O_mem_rden(c_mem_rden), .O_mem_wren(c_mem_wren),
      .O_mem_data(c_mem_data), .I_mem_data(c_mem_rdata));

   // Memory for a: 16 locations keyed by addr[15:12], two-cycle read pipe.
   logic [7:0] mem0 [16];
   logic [7:0] p0, p1;
   assign a_mem_rdata = p1;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) mem0[i] <= 8'h00;
         mem0[6] <= 8'hA5;
         p0 <= 8'h00;
         p1 <= 8'h00;
      end else begin
         if (a_mem_wren) mem0[a_mem_addr[15:12]] <= a_mem_data;
         p0 <= a_mem_rden ? mem0[a_mem_addr[15:12]] : 8'h00;
         p1 <= p0;
      end
   end

   // Memory for b: read returns addr[7:0]^5A one cycle after the strobe.
   always @(posedge clk) begin
      if (b_mem_rden) b_mem_rdata <= b_mem_addr[7:0] ^ 8'h5A;
   end
   assign c_mem_rdata = 8'h00;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] req;
      logic [2:0] wren;
      logic [2:0] ack;
      logic       rden;
      logic       wr;
      logic [2:0] rvalid;
      logic [7:0] data;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 3'b000, 8'h00};
      vecs[1]  = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 3'b000, 8'h00};
      vecs[2]  = '{3'b111, 3'b000, 3'b100, 1'b1, 1'b0, 3'b001, 8'h4A};
      vecs[3]  = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 3'b010, 8'h4B};
      vecs[4]  = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 3'b100, 8'h48};
      vecs[5]  = '{3'b111, 3'b000, 3'b100, 1'b1, 1'b0, 3'b001, 8'h4A};
      vecs[6]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 8'h4B};
      vecs[7]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 8'h48};
      vecs[8]  = '{3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 3'b000, 8'h00};
      vecs[9]  = '{3'b011, 3'b001, 3'b001, 1'b0, 1'b1, 3'b000, 8'h00};
      vecs[10] = '{3'b110, 3'b000, 3'b010, 1'b1, 1'b0, 3'b010, 8'h4B};
      vecs[11] = '{3'b100, 3'b000, 3'b100, 1'b1, 1'b0, 3'b000, 8'h00};
      vecs[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 8'h4B};
      vecs[13] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 8'h48};

      rst = 1'b0;
      a_req = 2'b11; a_wren = 2'b00; a_addr = {16'h2222, 16'h1111}; a_wdata = 16'h0000;
      b_req = 3'b000; b_wren = 3'b000; b_addr = {16'h0012, 16'h0011, 16'h0010};
      b_wdata = 24'h0;
      c_req = 2'b00; c_wren = 2'b00; c_addr = {16'h0200, 16'h0100}; c_wdata = 16'h0;

      // Reset with requests pending.
      repeat (3) tick();
      check("rst_ack", a_ack, 0);
      check("rst_rvalid", a_rvalid, 0);
      check("rst_rden", a_mem_rden, 0);
      check("rst_wren", a_mem_wren, 0);
      check("rst_addr", a_mem_addr, 0);
      check("rst_mdata", a_mem_data, 0);
      check("rst_rdata", a_rd_data, 0);
      @(negedge clk) rst = 1'b1;
      tick();
      check("first_ack", a_ack, 2'b01);
      check("first_rden", a_mem_rden, 1);
      check("first_addr", a_mem_addr, 16'h1111);
      a_req = 2'b00;
      tick();
      check("idle_ack", a_ack, 2'b00);
      a_req = 2'b11;
      tick();
      check("ptr_after_rst", a_ack, 2'b10);
      a_req = 2'b00;
      repeat (5) tick();

      // Round-robin table over three channels.
      for (int k = 0; k < 14; k++) begin
         b_req  = vecs[k].req;
         b_wren = vecs[k].wren;
         tick();
         check($sformatf("rr_ack[%0d]", k), b_ack, vecs[k].ack);
         check($sformatf("rr_rden[%0d]", k), b_mem_rden, vecs[k].rden);
         check($sformatf("rr_wren[%0d]", k), b_mem_wren, vecs[k].wr);
         check($sformatf("rr_rvalid[%0d]", k), b_rvalid, vecs[k].rvalid);
         if (vecs[k].rvalid != 3'b000)
            check($sformatf("rr_data[%0d]", k), b_rd_data, vecs[k].data);
      end

      // Fixed priority: both held, ch0 masked after each ack.
      c_req = 2'b11;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("fp_ack[%0d]", k), c_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("fp_rden[%0d]", k), c_mem_rden, 1);
      end
      c_req = 2'b00; tick(); check("fp_idle0", c_ack, 2'b00);
      c_req = 2'b01; tick(); check("fp_ch0", c_ack, 2'b01);
      c_req = 2'b00; tick(); check("fp_idle1", c_ack, 2'b00);
      c_req = 2'b11; tick(); check("fp_lowest", c_ack, 2'b01);
      c_req = 2'b00;

      // Read latency 2 on ch1.
      a_addr[31:16] = 16'h6000; a_req = 2'b10; a_wren = 2'b00;
      tick();
      check("lat_ack", a_ack, 2'b10);
      check("lat_rden", a_mem_rden, 1);
      check("lat_addr", a_mem_addr, 16'h6000);
      a_req = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("lat_rvalid[%0d]", i), a_rvalid, (i == 3) ? 2'b10 : 2'b00);
         if (i == 3) check("lat_data", a_rd_data, 8'hA5);
      end

      // Write on ch0 then read of the same address on ch1.
      a_addr[15:0] = 16'hC000; a_wdata[7:0] = 8'h3C; a_wren = 2'b01; a_req = 2'b01;
      tick();
      check("wr_ack", a_ack, 2'b01);
      check("wr_wren", a_mem_wren, 1);
      check("wr_rden", a_mem_rden, 0);
      check("wr_addr", a_mem_addr, 16'hC000);
      check("wr_mdata", a_mem_data, 8'h3C);
      a_req = 2'b10; a_wren = 2'b00; a_addr[31:16] = 16'hC000;
      tick();
      check("rd_ack", a_ack, 2'b10);
      check("rd_rden", a_mem_rden, 1);
      check("rd_wren", a_mem_wren, 0);
      check("rd_addr", a_mem_addr, 16'hC000);
      a_req = 2'b00;
      for (int i = 2; i <= 5; i++) begin
         tick();
         check($sformatf("wr_rd_rvalid[%0d]", i), a_rvalid, (i == 4) ? 2'b10 : 2'b00);
         if (i == 4) check("wr_rd_data", a_rd_data, 8'h3C);
      end

      // Reset while a read is in flight.
      a_addr[15:0] = 16'h6000; a_req = 2'b01; a_wren = 2'b00;
      tick();
      check("mid_ack", a_ack, 2'b01);
      a_req = 2'b00;
      tick();
      @(negedge clk) rst = 1'b0;
      #1;
      check("mid_rst_rden", a_mem_rden, 0);
      check("mid_rst_ack", a_ack, 0);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("mid_rvalid[%0d]", i), a_rvalid, 2'b00);
      end
      a_req = 2'b11;
      tick();
      check("mid_restart", a_ack, 2'b01);
      a_req = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that shares one single-port synchronous memory among several bus masters: CPU core, video fetch, and future DMA/audio.
- Generalises the fixed two-port CPU/video memory hookup to P_chans channels.
- Selectable fixed-priority or round-robin arbitration.
- Per-channel read-data return tagging through a latency-matched pipeline.

Parameters:
- P_chans, 2, number of requesting channels (2..8).
- P_addr_bits, 16, address width per channel and to memory.
- P_data_bits, 8, data width.
- P_rd_latency, 1, memory read latency in cycles from registered O_mem_rden to valid I_mem_data (1..4).
- P_mode, 1, 0 = fixed priority (lowest channel index wins), 1 = round-robin.

Ports:
- I_clock  in  1  system clock; all state on rising edge.
- I_reset  in  1  asynchronous, active-low reset.
- I_req  in  P_chans  per-channel request, held until acked.
- I_wren  in  P_chans  per-channel access type: 1 = write, 0 = read; valid with I_req.
- I_addr  in  P_chans*P_addr_bits  channel i address at bits [i*P_addr_bits +: P_addr_bits].
- I_wr_data  in  P_chans*P_data_bits  channel i write data at bits [i*P_data_bits +: P_data_bits].
- O_ack  out  P_chans  one-hot, one-cycle pulse; request accepted this cycle.
- O_rvalid  out  P_chans  one-hot, one-cycle pulse; O_rd_data belongs to this channel.
- O_rd_data  out  P_data_bits  returned read data, registered.
- O_mem_addr  out  P_addr_bits  memory address, registered.
- O_mem_rden  out  1  memory read strobe, registered.
- O_mem_wren  out  1  memory write strobe, registered.
- O_mem_data  out  P_data_bits  memory write data, registered.
- I_mem_data  in  P_data_bits  memory read data.

Behaviour:
- Reset (I_reset low, asynchronous):
  - O_ack, O_rvalid, O_mem_rden, O_mem_wren = 0.
  - O_mem_addr, O_mem_data, O_rd_data = 0.
  - Round-robin pointer = 0.
  - Read-tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and no O_rvalid is produced for them. The first grant after release follows the same rules as from power-up.
- Eligible set at each edge: I_req & ~O_ack. The channel acked in the current cycle cannot be granted at the following edge, which prevents a double grant while the requester drops or changes I_req.
- Grant selection, at most one grant per edge:
  - P_mode = 0: lowest-index eligible channel.
  - P_mode = 1: first eligible channel at or after the pointer, searching upward with wrap-around from P_chans-1 to 0. On a grant g, pointer <= (g+1) mod P_chans. With no grant, the pointer holds.
- On a grant to channel g, at the edge (cycle A):
  - O_ack[g] = 1.
  - O_mem_addr <= addr[g].
  - O_mem_wren <= I_wren[g].
  - O_mem_rden <= ~I_wren[g].
  - O_mem_data <= wr_data[g].
- No grant: O_mem_rden = O_mem_wren = 0; O_mem_addr and O_mem_data hold their last values.
- Read return:
  - A tag pipeline of depth P_rd_latency carries {valid, g}.
  - I_mem_data is sampled in cycle A+P_rd_latency.
  - O_rd_data and O_rvalid[g] are driven in cycle A+P_rd_latency+1.
  - Writes produce no O_rvalid.
- Throughput:
  - Back-to-back grants to different channels: one memory access per cycle.
  - A single channel alone: at most one access every 2 cycles.
- Pipelining: read returns are in issue order. Multiple reads may be in flight and may interleave with writes.
- Read/write ordering: a write issued at A followed by a read of the same address at A+1 returns the written data. This relies on memory write-first ordering and is not forwarded inside the arbiter.
- Starvation: P_mode = 1 guarantees a held request is acked within P_chans grants. P_mode = 0 gives no guarantee.
- Ack is not a function of I_wren; reads and writes arbitrate identically.

Test Plan:
- Reset: assert I_reset=0 with I_req=2'b11 → all outputs 0. Release; the first edge acks channel 0; the pointer becomes 1.
- Round-robin, P_chans=3, all requests held continuously → O_ack sequence 001, 010, 100, 001, ...; O_mem_rden high every cycle.
- Fixed priority, P_mode=0, channels 0 and 1 both requesting (ch0 re-requests after each ack) → ch0 acked every other cycle, ch1 acked in the gap cycles.
- Read latency, P_rd_latency=2: ch1 reads addr 16'h6000 (memory holds 8'hA5), acked cycle 5 → I_mem_data sampled cycle 7; O_rvalid=2'b10 and O_rd_data=8'hA5 in cycle 8.
- Write then read: ch0 writes 8'h3C to 16'hC000, then ch1 reads 16'hC000 next cycle → O_mem_wren then O_mem_rden on consecutive cycles; ch1 receives 8'h3C; no O_rvalid for ch0.
- Reset mid-read: read acked, I_reset pulsed low before the return → O_rvalid never asserts; arbitration restarts at channel 0.
